mem_req_sequencer: RTL and testbench

MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

---
 rtl/mem_seq_pkg.sv | 38 +++
 rtl/mem_req_fifo.sv | 69 ++++++
 rtl/mem_req_sequencer.sv | 137 +++++++++++++
 tb/tb_mem_req_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory request sequencer.
// MEM_REQ_SEQ_READBACK_EN adds the StChk state used for write readback checking.
package mem_seq_pkg;

    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

    // Command fields are sized for the widest supported configuration (ADDR_W, DATA_W <= 32);
    // narrower instances zero-extend on entry and slice on exit.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef struct packed {
        logic                  rw;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } mem_cmd_t;

`ifdef MEM_REQ_SEQ_READBACK_EN
    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StCap,
        StRsp,
        StChk
    } seq_state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StCap,
        StRsp
    } seq_state_e;
`endif

endpackage

// File: rtl/mem_req_fifo.sv
// Command queue for the memory request sequencer: power-of-two depth, first-word fall-through.
module mem_req_fifo
    import mem_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         cmd_t = mem_cmd_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cmd_t             storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// Queues read/write commands and plays them one at a time onto a registered-read memory port.
// Defining MEM_REQ_SEQ_READBACK_EN re-reads every write and flags mismatches on wb_err.
module mem_req_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_err
);

    seq_state_e        state_q, state_d;
    mem_cmd_t          push_cmd, head_cmd;
    mem_cmd_t          cur_q, cur_d;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              unused_cur;
`ifdef MEM_REQ_SEQ_READBACK_EN
    logic              wb_err_q, wb_err_d;
`endif

    always_comb begin
        push_cmd       = '0;
        push_cmd.rw    = req_rw;
        push_cmd.addr  = CMD_ADDR_W'(req_addr);
        push_cmd.wdata = CMD_DATA_W'(req_wdata);
    end

    assign req_ready = !fifo_full;

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .cmd_t (mem_cmd_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rsp_data_d = rsp_data_q;
        fifo_pop   = 1'b0;
`ifdef MEM_REQ_SEQ_READBACK_EN
        wb_err_d   = wb_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = head_cmd;
                    state_d  = (head_cmd.rw == MEM_READ) ? StRd : StWr;
                end
            end
`ifdef MEM_REQ_SEQ_READBACK_EN
            StWr: state_d = StRd;
            // A write command reaching StRd is its own readback, not a user read.
            StRd: state_d = (cur_q.rw == MEM_WRITE) ? StChk : StCap;
            StChk: begin
                if (mem_rdata != cur_q.wdata[DATA_W-1:0]) begin
                    wb_err_d = 1'b1;
                end
                state_d = StIdle;
            end
`else
            StWr: state_d = StIdle;
            StRd: state_d = StCap;
`endif
            StCap: begin
                rsp_data_d = mem_rdata;
                state_d    = StRsp;
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            rsp_data_q <= '0;
`ifdef MEM_REQ_SEQ_READBACK_EN
            wb_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rsp_data_q <= rsp_data_d;
`ifdef MEM_REQ_SEQ_READBACK_EN
            wb_err_q   <= wb_err_d;
`endif
        end
    end

    // Address/data hold the last command; only mem_rw decides whether memory is written.
    assign mem_rw      = (state_q == StWr) ? MEM_WRITE : MEM_READ;
    assign mem_address = cur_q.addr[ADDR_W-1:0];
    assign mem_data    = cur_q.wdata[DATA_W-1:0];
    assign rsp_valid   = (state_q == StRsp);
    assign rsp_data    = rsp_data_q;

`ifdef MEM_REQ_SEQ_READBACK_EN
    assign wb_err = wb_err_q;
`else
    assign wb_err = 1'b0;
`endif

    // Padding bits above ADDR_W/DATA_W are never observed.
    assign unused_cur = ^cur_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Randomised and directed bench for mem_req_sequencer against a command-level scoreboard.
// Build with MEM_REQ_SEQ_READBACK_EN to also exercise readback checking.
module tb_mem_req_sequencer;
    import mem_seq_pkg::*;

    localparam logic [7:0] STUCK_ADDR = 8'h22;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       mem_rw;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic [7:0] mem_rdata = '0;
    logic       wb_err;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned rsp_cnt  = 0;
    logic        mon_en   = 1'b1;
    logic        rand_done;

    logic [7:0]  mem_arr [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rsp_q [$];

    mem_req_sequencer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (8),
        .DATA_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .mem_rw      (mem_rw),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rdata   (mem_rdata),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory with registered read; under readback builds one address has bit 7 stuck at 1.
    always @(posedge clk) begin
        if (!mem_rw) begin
            mem_arr[mem_address] <= mem_data;
        end
`ifdef MEM_REQ_SEQ_READBACK_EN
        mem_rdata <= mem_arr[mem_address] | ((mem_address == STUCK_ADDR) ? 8'h80 : 8'h00);
`else
        mem_rdata <= mem_arr[mem_address];
`endif
    end

    function automatic logic [7:0] ref_read(input logic [7:0] a);
        logic [7:0] v;
        v = ref_mem[a];
`ifdef MEM_REQ_SEQ_READBACK_EN
        if (a == STUCK_ADDR) v = v | 8'h80;
`endif
        return v;
    endfunction

    // Scoreboard: accepted commands update the reference memory in order and predict
    // the exact memory write stream and response stream.
    always @(negedge clk) begin
        if (reset && mon_en) begin
            if (req_valid && req_ready) begin
                if (req_rw == MEM_WRITE) begin
                    exp_wr_q.push_back({req_addr, req_wdata});
                    ref_mem[req_addr] = req_wdata;
                end else begin
                    exp_rsp_q.push_back(ref_read(req_addr));
                end
            end
            if (!mem_rw) begin
                check_eq("mem_wr_expected", exp_wr_q.size() > 0, 1);
                if (exp_wr_q.size() > 0) begin
                    check_eq("mem_wr", {mem_address, mem_data}, exp_wr_q.pop_front());
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                check_eq("rsp_expected", exp_rsp_q.size() > 0, 1);
                if (exp_rsp_q.size() > 0) begin
                    check_eq("rsp_data", rsp_data, exp_rsp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic rw, input logic [7:0] addr, input logic [7:0] data);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = data;
        while (1) begin
            @(negedge clk);
            if (req_ready || waited > 300) break;
            waited++;
        end
        check_eq("req_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_wr_q.size() != 0 || exp_rsp_q.size() != 0) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_eq("drain_empty", exp_wr_q.size() + exp_rsp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_mem_rw"}, mem_rw, 1);
        check_eq({tag, "_mem_address"}, mem_address, 0);
        check_eq({tag, "_mem_data"}, mem_data, 0);
        check_eq({tag, "_wb_err"}, wb_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rw;
        logic [7:0] addr, data;
        int unsigned cnt0, gap;

        #2 reset = 1'b0;
        #1 check_reset_values("por");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Write then read 0x10: one-cycle write strobe at E2, response after E3.
        send(MEM_WRITE, 8'h10, 8'hA5);
        @(negedge clk); check_eq("wr_e1_rw", mem_rw, 1);
        @(negedge clk); check_eq("wr_e2_rw", mem_rw, 0);
        check_eq("wr_e2_addr", mem_address, 8'h10);
        check_eq("wr_e2_data", mem_data, 8'hA5);
        @(negedge clk); check_eq("wr_e3_rw", mem_rw, 1);
        drain();
        send(MEM_READ, 8'h10, 8'h00);
        @(negedge clk); check_eq("rd_e1_valid", rsp_valid, 0);
        @(negedge clk); check_eq("rd_e2_rw", mem_rw, 1);
        check_eq("rd_e2_addr", mem_address, 8'h10);
        @(negedge clk); check_eq("rd_e3_valid", rsp_valid, 0);
        @(negedge clk); check_eq("rd_e4_valid", rsp_valid, 1);
        check_eq("rd_e4_data", rsp_data, 8'hA5);
        @(negedge clk); check_eq("rd_one_cycle", rsp_valid, 0);
        drain();

        // Address wrap boundary values.
        send(MEM_WRITE, 8'h00, 8'h3C);
        send(MEM_WRITE, 8'hFF, 8'hFF);
        send(MEM_READ, 8'hFF, 8'h00);
        send(MEM_READ, 8'h00, 8'h00);
        drain();

        // Back-pressure: 1 in flight + 4 queued fills the FIFO.
        for (int i = 0; i < 6; i++) send(MEM_WRITE, 8'h40 + 8'(i), 8'h50 + 8'(i));
        drain();
        cnt0 = rsp_cnt;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(MEM_READ, 8'h40 + 8'(i), 8'h00);
        @(negedge clk); check_eq("full_ready", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_rw = MEM_READ; req_addr = 8'h45;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check_eq("full_hold", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(MEM_READ, 8'h45, 8'h00);
        drain();
        check_eq("bp_rsp_count", rsp_cnt - cnt0, 6);

        // Reset while the second of five reads is in RD with three still queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(MEM_READ, 8'h40 + 8'(i), 8'h00);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_rd_addr", mem_address, 8'h41);
        check_eq("pre_rst_ready", req_ready, 1);
        reset = 1'b0;
        #1 check_reset_values("mid_rst");
        exp_rsp_q.delete();
        exp_wr_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cnt0 = rsp_cnt;
        repeat (20) @(posedge clk);
        #1 check_eq("no_rsp_after_rst", rsp_cnt - cnt0, 0);
        check_eq("post_rst_ready", req_ready, 1);

`ifdef MEM_REQ_SEQ_READBACK_EN
        send(MEM_WRITE, 8'h30, 8'h0F);
        drain();
        check_eq("wb_good", wb_err, 0);
        send(MEM_WRITE, STUCK_ADDR, 8'h0F);
        @(negedge clk); @(negedge clk);
        @(negedge clk); check_eq("wb_e3", wb_err, 0);
        @(negedge clk); check_eq("wb_e4", wb_err, 0);
        @(negedge clk); check_eq("wb_set", wb_err, 1);
        send(MEM_WRITE, 8'h31, 8'h0F);
        drain();
        check_eq("wb_sticky", wb_err, 1);
        reset = 1'b0;
        #1 check_eq("wb_cleared", wb_err, 0);
        @(posedge clk); #1 reset = 1'b1;
`endif

        // Pointer wrap with ten back-to-back commands, then randomised traffic.
        for (int i = 0; i < 10; i++) begin
            send(i[0] ? MEM_READ : MEM_WRITE, 8'h80 + 8'(i / 2), 8'(i * 17 + 3));
        end
        drain();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rw   = 1'($urandom_range(0, 1));
                    addr = 8'($urandom_range(0, 15)) | 8'h60;
                    data = 8'($urandom);
                    send(rw, addr, data);
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        check_eq("final_wb_err", wb_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
